// File: rtl/ifetch_ctrl_if.sv
// Fetch-controller bus: run/step/stall controls, branch/jump redirect,
// and the instruction-memory address/data path plus status outputs.
interface ifetch_ctrl_if;
    logic        run;
    logic        step;
    logic        stall;
    logic        branch;
    logic [15:0] br_offset;
    logic        jump;
    logic [25:0] j_addr;
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] pc4;
    logic [31:0] inst_out;
    logic        inst_valid;
    logic [1:0]  state;
    logic        halted;
    logic [15:0] fetch_count;

    modport master (
        input  run, step, stall, branch, br_offset, jump, j_addr, inst,
        output addr, pc4, inst_out, inst_valid, state, halted, fetch_count
    );

    modport slave (
        output run, step, stall, branch, br_offset, jump, j_addr, inst,
        input  addr, pc4, inst_out, inst_valid, state, halted, fetch_count
    );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the combinational imem,
// and sequences run / single-step / stall with a sticky halt on bad fetches.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 32
) (
    input  logic         clk,
    input  logic         rst,
    ifetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        HALT = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc, pc4, next_pc, br_target;
    logic [15:0] fetch_count;
    logic        in_range, active, valid, advance;

    always_comb begin
        pc4       = pc + 32'd4;
        br_target = pc4 + {{14{bus.br_offset[15]}}, bus.br_offset, 2'b00};
        in_range  = (pc[1:0] == 2'b00) && ({2'b00, pc[31:2]} < 32'(IMEM_WORDS));
        active    = (state_q == RUN) || (state_q == STEP);
        valid     = active && in_range;
        advance   = valid && !bus.stall;
        if (bus.jump)
            next_pc = {pc4[31:28], bus.j_addr, 2'b00};
        else if (bus.branch)
            next_pc = br_target;
        else
            next_pc = pc4;
    end

    // A bad fetch halts on the next edge even under stall.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.run)
                    state_d = RUN;
                else if (bus.step)
                    state_d = STEP;
            end
            RUN: begin
                if (!in_range)
                    state_d = HALT;
                else if (!bus.run)
                    state_d = IDLE;
            end
            STEP: begin
                if (!in_range)
                    state_d = HALT;
                else if (!bus.stall)
                    state_d = IDLE;
            end
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc          <= RESET_PC;
            fetch_count <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (advance) begin
                pc <= next_pc;
                if (fetch_count != 16'hFFFF)
                    fetch_count <= fetch_count + 16'd1;
            end
        end
    end

    assign bus.addr        = pc;
    assign bus.pc4         = pc4;
    assign bus.inst_valid  = valid;
    assign bus.inst_out    = valid ? bus.inst : 32'h0;
    assign bus.state       = state_q;
    assign bus.halted      = (state_q == HALT);
    assign bus.fetch_count = fetch_count;
endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed scenarios plus random control traffic,
// all checked against a behavioural PC/state/count model.
module tb_ifetch_ctrl;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          IMEM_WORDS = 32;
    localparam logic [1:0]  S_IDLE = 2'd0, S_RUN = 2'd1, S_STEP = 2'd2, S_HALT = 2'd3;

    logic clk, rst;
    ifetch_ctrl_if bus();

    ifetch_ctrl #(.RESET_PC(RESET_PC), .IMEM_WORDS(IMEM_WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] imem(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign bus.inst = imem(bus.addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // reference model
    logic [31:0] m_pc;
    logic [1:0]  m_st;
    int          m_cnt;

    function automatic bit m_in_range();
        return (longint'(m_pc) % 4 == 0) && (longint'(m_pc) / 4 < IMEM_WORDS);
    endfunction

    function automatic bit m_valid();
        return (m_st == S_RUN || m_st == S_STEP) && m_in_range();
    endfunction

    task automatic model_reset();
        m_pc  = RESET_PC;
        m_st  = S_IDLE;
        m_cnt = 0;
    endtask

    task automatic model_edge();
        bit          fetching, inr;
        logic [31:0] seq;
        logic [1:0]  nst;
        inr      = m_in_range();
        fetching = m_valid();
        nst      = m_st;
        if (m_st == S_IDLE) nst = bus.run ? S_RUN : (bus.step ? S_STEP : S_IDLE);
        else if (m_st == S_RUN) nst = !inr ? S_HALT : (bus.run ? S_RUN : S_IDLE);
        else if (m_st == S_STEP) nst = !inr ? S_HALT : (bus.stall ? S_STEP : S_IDLE);
        if (fetching && !bus.stall) begin
            seq = m_pc + 32'd4;
            if (bus.jump)
                m_pc = {seq[31:28], bus.j_addr, 2'b00};
            else if (bus.branch)
                m_pc = seq + 32'(int'($signed(bus.br_offset)) * 4);
            else
                m_pc = seq;
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        end
        m_st = nst;
    endtask

    task automatic check_outs();
        chk("addr",        bus.addr,        m_pc);
        chk("pc4",         bus.pc4,         m_pc + 32'd4);
        chk("inst_valid",  {31'b0, bus.inst_valid}, {31'b0, m_valid()});
        chk("inst_out",    bus.inst_out,    m_valid() ? imem(m_pc) : 32'h0);
        chk("state",       {30'b0, bus.state}, {30'b0, m_st});
        chk("halted",      {31'b0, bus.halted}, {31'b0, m_st == S_HALT});
        chk("fetch_count", {16'b0, bus.fetch_count}, 32'(m_cnt));
    endtask

    // called at posedge+1; leaves time at next posedge+1
    task automatic cyc(input bit r, input bit s, input bit st, input bit br,
                       input logic [15:0] bo, input bit j, input logic [25:0] ja);
        bus.run = r; bus.step = s; bus.stall = st;
        bus.branch = br; bus.br_offset = bo; bus.jump = j; bus.j_addr = ja;
        #1;
        check_outs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.run = 0; bus.step = 0; bus.stall = 0; bus.branch = 0; bus.jump = 0;
        model_reset();
        #1;
        check_outs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] held_cnt;
        rst = 1'b1;
        bus.run = 0; bus.step = 0; bus.stall = 0; bus.branch = 0;
        bus.br_offset = 16'h0; bus.jump = 0; bus.j_addr = 26'h0;
        model_reset();
        #1;
        check_outs();
        chk("rst_addr", bus.addr, RESET_PC);
        chk("rst_inst_out", bus.inst_out, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // sequential run
        cyc(1, 0, 0, 0, 16'h0, 0, 26'h0);
        chk("run_state", {30'b0, bus.state}, {30'b0, S_RUN});
        for (int i = 0; i < 4; i++) begin
            chk("seq_addr", bus.addr, 32'(i * 4));
            cyc(1, 0, 0, 0, 16'h0, 0, 26'h0);
        end
        chk("seq_count", {16'b0, bus.fetch_count}, 32'd4);

        // branch / jump
        cyc(1, 0, 0, 0, 16'h0, 1, 26'hB);
        chk("jmp_2c", bus.addr, 32'h2C);
        cyc(1, 0, 0, 1, 16'h0001, 0, 26'h0);
        chk("br_34", bus.addr, 32'h34);
        cyc(1, 0, 0, 1, 16'h0002, 0, 26'h0);
        chk("br_40", bus.addr, 32'h40);
        cyc(1, 0, 0, 0, 16'h0, 1, 26'h1);
        chk("jmp_04", bus.addr, 32'h04);
        cyc(1, 0, 0, 0, 16'h0, 1, 26'h4);
        cyc(1, 0, 0, 1, 16'hFFFF, 0, 26'h0);
        chk("br_back", bus.addr, 32'h10);

        // stall with branch pending, then jump beats branch
        cyc(1, 0, 0, 0, 16'h0, 1, 26'h2);
        held_cnt = bus.fetch_count;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 1, 1, 16'h0005, 0, 26'h0);
            chk("stall_addr", bus.addr, 32'h8);
            chk("stall_valid", {31'b0, bus.inst_valid}, 32'd1);
            chk("stall_cnt", {16'b0, bus.fetch_count}, {16'b0, held_cnt});
        end
        cyc(1, 0, 0, 1, 16'h0005, 1, 26'h3);
        chk("jmp_wins", bus.addr, 32'hC);

        // single step held by stall
        do_reset();
        cyc(0, 1, 1, 0, 16'h0, 0, 26'h0);
        for (int i = 0; i < 2; i++) begin
            chk("step_hold", {30'b0, bus.state}, {30'b0, S_STEP});
            cyc(0, 0, 1, 0, 16'h0, 0, 26'h0);
        end
        chk("step_pc0", bus.addr, 32'h0);
        cyc(0, 0, 0, 0, 16'h0, 0, 26'h0);
        chk("step_idle", {30'b0, bus.state}, {30'b0, S_IDLE});
        chk("step_pc4", bus.addr, 32'h4);
        chk("step_cnt", {16'b0, bus.fetch_count}, 32'd1);

        // out-of-range halt
        do_reset();
        cyc(1, 0, 0, 0, 16'h0, 0, 26'h0);
        cyc(1, 0, 0, 0, 16'h0, 1, 26'h20);
        chk("oor_addr", bus.addr, 32'h80);
        chk("oor_valid", {31'b0, bus.inst_valid}, 32'd0);
        chk("oor_inst", bus.inst_out, 32'h0);
        cyc(1, 0, 1, 0, 16'h0, 0, 26'h0);
        chk("halt_state", {30'b0, bus.state}, {30'b0, S_HALT});
        chk("halt_flag", {31'b0, bus.halted}, 32'd1);
        for (int i = 0; i < 8; i++)
            cyc(1'($urandom), 1'($urandom), 1'($urandom), 0, 16'h0, 0, 26'h0);
        chk("halt_sticky", {30'b0, bus.state}, {30'b0, S_HALT});
        chk("halt_addr", bus.addr, 32'h80);

        // async reset while stalled in RUN at 0x24
        do_reset();
        cyc(1, 0, 0, 0, 16'h0, 0, 26'h0);
        cyc(1, 0, 0, 0, 16'h0, 1, 26'h9);
        chk("pre_rst_addr", bus.addr, 32'h24);
        bus.stall = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        chk("async_addr", bus.addr, RESET_PC);
        chk("async_state", {30'b0, bus.state}, {30'b0, S_IDLE});
        chk("async_cnt", {16'b0, bus.fetch_count}, 32'd0);
        model_reset();
        bus.stall = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // random traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 39) == 0 || (m_st == S_HALT && $urandom_range(0, 3) == 0))
                do_reset();
            else
                cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    16'($urandom_range(0, 16) - 8), $urandom_range(0, 7) == 0,
                    26'($urandom_range(0, IMEM_WORDS + 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch sequencer for the single-cycle CPU. It owns the program counter, drives the word address into the combinational instruction memory and selects the next PC from sequential, branch and jump sources. It provides run, single-step and stall control, and halts on out-of-range fetches. It sits between the instruction memory and the decode/control stage, replacing the free-running PC register.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 32, number of valid 32-bit words in instruction memory (power of two, ≥2).
- Clk  in  1  rising-edge clock.
- Rst  in  1  reset: asynchronous, active-high.
- Run  in  1  level: continuous fetch while high.
- Step  in  1  one-cycle pulse: fetch and retire exactly one instruction from IDLE.
- Stall  in  1  hold current PC/instruction this cycle.
- Branch  in  1  taken-branch indication for the current instruction (beq/bne already resolved).
- BrOffset  in  16  branch immediate, in words, signed.
- Jump  in  1  current instruction is j.
- JAddr  in  26  jump target field.
- Inst  in  32  instruction word returned by instruction memory (same cycle as Addr).
- Addr  out  32  byte address to instruction memory; equals PC.
- PC4  out  32  PC + 4.
- InstOut  out  32  Inst when InstValid, else 32'h0.
- InstValid  out  1  current InstOut is a real fetch to execute.
- State  out  2  00 IDLE, 01 RUN, 10 STEP, 11 HALT.
- Halted  out  1  State == HALT.
- FetchCount  out  16  instructions retired since reset, saturating.

## Operation
- FSM, registered state:
  - IDLE: Run=1 -> RUN. Otherwise Step=1 -> STEP. Run wins if both are high.
  - RUN: Run=0 -> IDLE, with PC unchanged if stalled. Step is ignored.
  - STEP: on the first non-stalled cycle, retire one instruction and go to IDLE. While Stall=1, stay in STEP.
  - HALT: sticky. Only Rst exits.
- Out-of-range: in RUN or STEP, if PC[1:0] != 0 or PC[31:2] ≥ IMEM_WORDS:
  - InstValid=0 that cycle and the PC is not updated.
  - The next edge enters HALT, regardless of Stall.
- InstValid = (State==RUN or STEP) and PC in range.
- Advance = InstValid and not Stall. On Advance the PC loads NextPC and FetchCount increments, saturating at 16'hFFFF.
- NextPC priority, Jump > Branch > sequential:
  - Jump: {PC4[31:28], JAddr, 2'b00}.
  - Branch: PC4 + ({{14{BrOffset[15]}}, BrOffset, 2'b00}), with 32-bit wrap-around.
  - Otherwise: PC4.
- Branch and Jump are ignored unless Advance.
- PC4 = PC + 4, modulo 2^32.

## Timing
- Reset (asynchronous, immediate):
  - PC = RESET_PC, State = IDLE, FetchCount = 0.
  - Therefore Addr = RESET_PC, PC4 = RESET_PC+4, InstValid = 0, InstOut = 0, Halted = 0.
- Reset asserted mid-RUN or mid-Stall aborts the fetch with no retirement counted.
- Addr is a direct register output. Inst is combinational and returns in the same cycle, so fetch-to-InstOut latency is 0 cycles.
- PC, State and FetchCount update only on the rising Clk edge.
- Stall=1 holds PC and InstOut stable and keeps InstValid high for as many cycles as asserted.
- IDLE -> RUN costs one cycle: the first instruction becomes valid in the cycle after Run is sampled high.
- STEP: exactly one Advance edge, then IDLE. A Step pulse arriving while in RUN or HALT is dropped.
- Run dropping in the same cycle as Advance: the PC still advances on that edge, then State goes to IDLE.

## Test plan
- Reset/sequential run: Rst pulse, then Run=1 with no Branch/Jump for 4 cycles.
  - Addr must read 0x0, 0x4, 0x8, 0xC on consecutive cycles after entering RUN.
  - FetchCount must read 4.
- Branch/jump: at PC 0x2C, Branch=1, BrOffset=16'h0001 -> next Addr 0x34.
  - At PC 0x34, Branch=1, BrOffset=16'h0002 -> 0x40.
  - At PC 0x40, Jump=1, JAddr=26'h1 -> 0x04.
  - Backward branch: BrOffset=16'hFFFF at PC 0x10 -> 0x10.
- Stall/priority: Stall=1 for 3 cycles at PC 0x8 with Branch=1.
  - PC holds 0x8, InstValid stays 1, FetchCount is unchanged.
  - On release with Branch=1, Jump=1, JAddr=26'h3 -> 0xC (jump wins over branch).
- Single-step: from IDLE, pulse Step while Stall=1 for 2 cycles.
  - State stays STEP until Stall drops.
  - Exactly one PC advance (0x0 -> 0x4), then State=IDLE; FetchCount=1.
- Out-of-range halt: Jump=1, JAddr=26'h20 -> Addr 0x80.
  - That cycle: InstValid=0 and InstOut=0.
  - Next edge: State=11, Halted=1. Run, Step and Stall toggling have no effect afterwards.
- Async reset mid-run: assert Rst between edges while in RUN at PC 0x24.
  - Addr=RESET_PC, State=00 and FetchCount=0 immediately, without waiting for a clock edge.
